// File: rtl/parser.sv
// Receive-side front end: rebuilds 16-bit puzzle words from UART bytes and
// decodes dimensions and clues into registered one-cycle strobes.
module parser #(
    parameter int MAX_DIM = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] byte_in,
    output logic [3:0] n,
    output logic [3:0] m,
    output logic       size_valid,
    output logic       clue_valid,
    output logic [3:0] clue_value,
    output logic [4:0] clue_line,
    output logic [2:0] clue_group,
    output logic [2:0] clue_pos,
    output logic       line_done,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT_N    = 3'd0,
        S_WAIT_M    = 3'd1,
        S_WAIT_LINE = 3'd2,
        S_IN_LINE   = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    localparam logic [2:0] OP_START      = 3'b111;
    localparam logic [2:0] OP_LINE_START = 3'b110;
    localparam logic [2:0] OP_VALUE      = 3'b101;
    localparam logic [2:0] OP_GROUP_SEP  = 3'b010;
    localparam logic [2:0] OP_LINE_END   = 3'b001;
    localparam logic [2:0] OP_STOP       = 3'b000;
    localparam logic [3:0] MAX_V         = 4'(MAX_DIM);

    state_t      state, state_d;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [4:0]  lines, lines_d;
    logic [2:0]  group, group_d;
    // pos is one bit wider so a ninth VALUE in a group can be detected
    logic [3:0]  pos, pos_d;

    logic [3:0]  n_d, m_d, clue_value_d;
    logic [4:0]  clue_line_d;
    logic [2:0]  clue_group_d, clue_pos_d;
    logic        size_valid_d, clue_valid_d, line_done_d, done_d, error_d;

    logic [15:0] word;
    logic [2:0]  op;
    logic [3:0]  val;
    logic [4:0]  total;
    logic        word_ok, dim_ok, bad;

    assign word      = {hi_byte, byte_in};
    assign op        = word[15:13];
    assign val       = word[3:0];
    assign total     = {1'b0, n} + {1'b0, m};
    assign word_ok   = valid_in & phase;
    assign dim_ok    = (val != 4'd0) && (val <= MAX_V);
    assign dbg_state = state;

    always_comb begin
        state_d      = state;
        n_d          = n;
        m_d          = m;
        lines_d      = lines;
        group_d      = group;
        pos_d        = pos;
        size_valid_d = 1'b0;
        clue_valid_d = 1'b0;
        line_done_d  = 1'b0;
        clue_value_d = clue_value;
        clue_line_d  = clue_line;
        clue_group_d = clue_group;
        clue_pos_d   = clue_pos;
        done_d       = done;
        error_d      = error;
        bad          = 1'b0;
        if (word_ok) begin
            case (state)
                S_WAIT_N: begin
                    if (op == OP_START && dim_ok) begin
                        n_d     = val;
                        state_d = S_WAIT_M;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_WAIT_M: begin
                    if (op == OP_START && dim_ok) begin
                        m_d          = val;
                        size_valid_d = 1'b1;
                        state_d      = S_WAIT_LINE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_WAIT_LINE: begin
                    if (op == OP_LINE_START && lines != total) begin
                        group_d = 3'd0;
                        pos_d   = 4'd0;
                        state_d = S_IN_LINE;
                    end else if (op == OP_STOP && lines == total) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_IN_LINE: begin
                    if (op == OP_VALUE && !pos[3]) begin
                        clue_valid_d = 1'b1;
                        clue_value_d = val;
                        clue_line_d  = lines;
                        clue_group_d = group;
                        clue_pos_d   = pos[2:0];
                        pos_d        = pos + 4'd1;
                    end else if (op == OP_GROUP_SEP && group != 3'd7) begin
                        group_d = group + 3'd1;
                        pos_d   = 4'd0;
                    end else if (op == OP_LINE_END) begin
                        line_done_d = 1'b1;
                        clue_line_d = lines;
                        lines_d     = lines + 5'd1;
                        state_d     = S_WAIT_LINE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (bad) begin
            state_d = S_ERR;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_WAIT_N;
            phase      <= 1'b0;
            hi_byte    <= 8'd0;
            lines      <= 5'd0;
            group      <= 3'd0;
            pos        <= 4'd0;
            n          <= 4'd0;
            m          <= 4'd0;
            size_valid <= 1'b0;
            clue_valid <= 1'b0;
            line_done  <= 1'b0;
            clue_value <= 4'd0;
            clue_line  <= 5'd0;
            clue_group <= 3'd0;
            clue_pos   <= 3'd0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (valid_in) begin
                phase <= ~phase;
                if (!phase) hi_byte <= byte_in;
            end
            state      <= state_d;
            lines      <= lines_d;
            group      <= group_d;
            pos        <= pos_d;
            n          <= n_d;
            m          <= m_d;
            size_valid <= size_valid_d;
            clue_valid <= clue_valid_d;
            line_done  <= line_done_d;
            clue_value <= clue_value_d;
            clue_line  <= clue_line_d;
            clue_group <= clue_group_d;
            clue_pos   <= clue_pos_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_parser.sv
// Bench for parser: directed byte streams, strobe scoreboard fed at stimulus
// time and drained by a monitor on the falling edge.
module tb_parser;

    localparam int W = 17;
    localparam logic [1:0] K_SIZE = 2'd1;
    localparam logic [1:0] K_CLUE = 2'd2;
    localparam logic [1:0] K_LINE = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic [3:0] n, m, clue_value;
    logic       size_valid, clue_valid, line_done, done, error;
    logic [4:0] clue_line;
    logic [2:0] clue_group, clue_pos, dbg_state;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miss = 0;

    logic [7:0] line0_b[8];
    logic [7:0] line1_b[14];

    parser #(.MAX_DIM(11)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .byte_in(byte_in),
        .n(n), .m(m), .size_valid(size_valid), .clue_valid(clue_valid),
        .clue_value(clue_value), .clue_line(clue_line), .clue_group(clue_group),
        .clue_pos(clue_pos), .line_done(line_done), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(input logic [1:0] k, input logic [3:0] a,
                                        input logic [4:0] b, input logic [2:0] c,
                                        input logic [2:0] d);
        return {k, a, b, c, d};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miss++;
            $display("FAIL %s: %0d strobes still expected, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        byte_in = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        valid_in = 1'b1;
        byte_in = b;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic idle(input int cycles);
        valid_in = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_dims(input logic [3:0] nn, input logic [3:0] mm);
        exp_q.push_back(ev(K_SIZE, nn, {1'b0, mm}, 3'd0, 3'd0));
        send(8'hE0); idle(1); send({4'h0, nn}); idle(1);
        send(8'hE0); idle(1); send({4'h0, mm});
    endtask

    task automatic send_line0();
        exp_q.push_back(ev(K_CLUE, 4'd1, 5'd0, 3'd0, 3'd0));
        exp_q.push_back(ev(K_CLUE, 4'd3, 5'd0, 3'd0, 3'd1));
        exp_q.push_back(ev(K_LINE, 4'd0, 5'd0, 3'd0, 3'd0));
        for (int i = 0; i < 8; i++) send(line0_b[i]);
    endtask

    task automatic send_line1(input logic [4:0] ln);
        exp_q.push_back(ev(K_CLUE, 4'd1, ln, 3'd0, 3'd0));
        exp_q.push_back(ev(K_CLUE, 4'd2, ln, 3'd0, 3'd1));
        exp_q.push_back(ev(K_CLUE, 4'd0, ln, 3'd1, 3'd0));
        exp_q.push_back(ev(K_CLUE, 4'd3, ln, 3'd1, 3'd1));
        exp_q.push_back(ev(K_LINE, 4'd0, ln, 3'd0, 3'd0));
        for (int i = 0; i < 14; i++) send(line1_b[i]);
    endtask

    initial begin
        line0_b = '{8'hC0, 8'h00, 8'hA0, 8'h01, 8'hA0, 8'h03, 8'h20, 8'h00};
        line1_b = '{8'hC0, 8'h00, 8'hA0, 8'h01, 8'hA0, 8'h02, 8'h40, 8'h00,
                    8'hA0, 8'h00, 8'hA0, 8'h03, 8'h20, 8'h00};

        fork
            forever begin
                logic [W-1:0] act, expv;
                @(negedge clk);
                if (size_valid || clue_valid || line_done) begin
                    if (size_valid) act = ev(K_SIZE, n, {1'b0, m}, 3'd0, 3'd0);
                    else if (clue_valid) act = ev(K_CLUE, clue_value, clue_line, clue_group, clue_pos);
                    else act = ev(K_LINE, 4'd0, clue_line, 3'd0, 3'd0);
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miss++;
                        $display("FAIL strobe: got unexpected %h, expected none", act);
                    end else begin
                        expv = exp_q.pop_front();
                        if (act !== expv) begin
                            miss++;
                            $display("FAIL strobe: got %h, expected %h", act, expv);
                        end
                    end
                end
            end
        join_none

        // Reset values
        do_reset();
        @(negedge clk);
        check("reset_n", {4'h0, n}, 8'h00);
        check("reset_m", {4'h0, m}, 8'h00);
        check("reset_flags", {3'b0, size_valid, clue_valid, line_done, done, error}, 8'h00);
        check("reset_clue", {1'b0, clue_value, clue_pos}, 8'h00);
        check("reset_state", {5'd0, dbg_state}, 8'h00);
        idle(1);

        // Dimensions, then full puzzle
        send_dims(4'd4, 4'd4);
        idle(2);
        check("dims_n", {4'h0, n}, 8'h04);
        check("dims_m", {4'h0, m}, 8'h04);
        check_drained("dims_drain");
        send_line0();
        idle(1);
        check_drained("line0_drain");
        for (int l = 1; l < 8; l++) send_line1(5'(l));
        send(8'h00); send(8'h00);
        idle(1);
        check("full_done", {7'd0, done}, 8'h01);
        check("full_error", {7'd0, error}, 8'h00);
        send(8'hC0); send(8'h00); send(8'hA0); send(8'h01); send(8'h20); send(8'h00);
        idle(2);
        check("after_done", {6'd0, done, error}, 8'h02);
        check("full_keep_n", {n, m}, 8'h44);
        check_drained("full_drain");

        // Early STOP after 4 of 8 lines
        do_reset();
        send_dims(4'd4, 4'd4);
        send_line0();
        for (int l = 1; l < 4; l++) send_line1(5'(l));
        send(8'h00); send(8'h00);
        idle(1);
        check("early_flags", {6'd0, done, error}, 8'h01);
        send(8'hC0); send(8'h00); send(8'hA0); send(8'h01); send(8'h20); send(8'h00);
        idle(2);
        check("early_hold", {6'd0, done, error}, 8'h01);
        check_drained("early_drain");

        // Reset mid-word discards the pending high byte
        do_reset();
        send(8'hE0); send(8'h04); send(8'hE0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(ev(K_SIZE, 4'd5, 5'd3, 3'd0, 3'd0));
        send(8'hE0); send(8'h05); send(8'hE0); send(8'h03);
        idle(2);
        check("midword_nm", {n, m}, 8'h53);
        check("midword_error", {7'd0, error}, 8'h00);
        check_drained("midword_drain");

        // Dimension above MAX_DIM
        do_reset();
        send(8'hE0); send(8'h0C);
        idle(2);
        check("baddim_error", {6'd0, done, error}, 8'h01);
        check("baddim_n", {4'h0, n}, 8'h00);

        // Largest legal dimension, then an illegal opcode inside a line
        do_reset();
        send_dims(4'd11, 4'd1);
        exp_q.push_back(ev(K_CLUE, 4'd9, 5'd0, 3'd0, 3'd0));
        send(8'hC0); send(8'h00); send(8'hA0); send(8'h09);
        send(8'h60); send(8'h00);
        send(8'hA0); send(8'h01);
        idle(2);
        check("maxdim_nm", {n, m}, 8'hB1);
        check("badop_error", {6'd0, done, error}, 8'h01);
        check_drained("badop_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/parser.md
# parser

Receive-side front end of the nonogram solver. It takes the byte stream delivered by the UART receiver and reassembles it into 16-bit puzzle words. It decodes the puzzle dimensions and per-line clue values and presents them to the solver's clue storage as registered one-cycle strobes. It is the inverse of the solution assembler: the same 16-bit word framing, carried in the host-to-board direction.

## Interface
- `MAX_DIM`, default 11: largest legal row/column count.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `valid_in` input 1: `byte_in` valid this cycle; may be high on consecutive cycles.
- `byte_in` input 8: received byte.
- `n` output 4: row count, held after decode.
- `m` output 4: column count, held after decode.
- `size_valid` output 1: one-cycle pulse when `m` is decoded and both `n` and `m` are valid.
- `clue_valid` output 1: one-cycle pulse per VALUE word.
- `clue_value` output 4: value field of that word.
- `clue_line` output 5: line index. Rows are 0..n-1, columns are n..n+m-1.
- `clue_group` output 3: group index within the line.
- `clue_pos` output 3: VALUE index within the group.
- `line_done` output 1: one-cycle pulse on LINE_END. `clue_line` carries the finished line.
- `done` output 1: sticky; STOP accepted after exactly n+m lines.
- `error` output 1: sticky; protocol violation.

## Operation
- **Framing:** words are big-endian. The first accepted byte goes to a high register and a phase bit toggles; the second byte completes the word. Decoding uses opcode `word[15:13]`; the value is `word[3:0]`.
- **Opcodes:**
  - 111 START
  - 110 LINE_START
  - 101 VALUE
  - 010 GROUP_SEP
  - 001 LINE_END
  - 000 STOP
  - 011 and 100 are illegal.
- **States and transitions:**
  - WAIT_N: START with value v sets `n`=v, then go to WAIT_M.
  - WAIT_M: START with value v sets `m`=v, pulse `size_valid`, then go to WAIT_LINE.
  - WAIT_LINE:
    - LINE_START: clear group/pos, then go to IN_LINE.
    - STOP with lines == n+m: go to DONE.
  - IN_LINE:
    - VALUE: pulse `clue_valid`, then pos++.
    - GROUP_SEP: group++, pos=0.
    - LINE_END: pulse `line_done`, line++, then go to WAIT_LINE.
  - DONE and ERR: absorbing until reset. All input is ignored; no strobes are produced.
- **Errors** (go to ERR and set `error`):
  - An opcode not listed above for the current state.
  - START value 0 or greater than `MAX_DIM`.
  - LINE_START when lines == n+m.
  - STOP when lines ≠ n+m.
  - pos overflowing past 7, or group overflowing past 7.
- **Counters:** the line counter is 5 bits. n+m is computed at 5 bits, so no overflow is possible with `MAX_DIM` = 11.
- **Persistence:** `n` and `m` are never cleared except by reset.

## Timing
- All outputs are registered.
- **Reset values:** every output is 0, the state is WAIT_N, the phase is 0, and all counters are 0.
- **Latency:** each strobe asserts in the cycle after the clock edge that samples the second byte (`valid_in`=1) of its word.
- **Strobe width:** strobes are exactly one cycle wide, even with back-to-back words. No strobe is asserted when `valid_in` is low.
- `clue_line`, `clue_group` and `clue_pos` are valid with `clue_valid`; `clue_line` is valid with `line_done`.
- **Throughput:** one byte per cycle sustained; there is no backpressure.
- **Reset mid-word:** reset discards any partial high byte. The next byte is treated as a high byte.
- `done` and `error` are never both 1.

## Test plan
- **Dimensions:** bytes E0 04 E0 04 with gaps -> `n`=4, `m`=4, `size_valid` single pulse one cycle after the 4th byte; no other strobes.
- **Line 0:** after the dimensions, C0 00 A0 01 A0 03 20 00 -> `clue_valid` twice:
  - (value 1, line 0, group 0, pos 0)
  - (value 3, line 0, group 0, pos 1)
  - then `line_done` with line 0.
- **Line 1 with a group separator:** C0 00 A0 01 A0 02 40 00 A0 00 A0 03 20 00 -> clues:
  - (1, g0 p0), (2, g0 p1), (0, g1 p0), (3, g1 p1), all on line 1
  - then `line_done` with line 1.
- **Full puzzle:** 8 lines with the same bytes on consecutive cycles, then 00 00 -> `done`=1 two cycles after the last byte; `error` stays 0. Further bytes produce no strobes.
- **Early STOP:** 00 00 after 4 of 8 lines -> `error`=1, `done`=0, and subsequent valid LINE words are ignored.
- **Reset mid-word:** feed E0 04 E0, assert `rst` for one cycle, then feed E0 05 E0 03 -> `n`=5, `m`=3, `error`=0.
- **Bad dimension:** E0 0C -> `error`=1, `size_valid` never pulses.
